// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: single-port word memory with byte-lane writes, optional wait
// states and a two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_sram_slave #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        RESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADYIN,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA
);

   localparam int unsigned Words = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

   state_e                  state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic                    pend_q, pend_d;
   logic                    write_q;
   logic [ADDR_WIDTH-1:0]   waddr_q;
   logic [3:0]              be_q;
   logic [31:0]             mem [Words];

   logic       capture;
   logic       addr_err;
   logic       size_err;
   logic       hit_err;
   logic       commit;
   logic [3:0] be;
   logic       unused_in;

   assign unused_in = ^{HBURST, HPROT};

   assign HREADYOUT = (state_q != StWait) && (state_q != StErr1);
   assign HRESP     = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
   assign HRDATA    = (pend_q && !write_q) ? mem[waddr_q] : 32'h0;

   assign capture = HSEL && HREADYIN && HTRANS[1] && HREADYOUT;

   // Lane enables and error classification for the address currently on the bus
   always_comb begin
      addr_err = HADDR[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2];
      size_err = 1'b0;
      be       = 4'b0000;
      case (HSIZE)
         3'd0: be = 4'b0001 << HADDR[1:0];
         3'd1: begin
            be       = HADDR[1] ? 4'b1100 : 4'b0011;
            size_err = HADDR[0];
         end
         3'd2: begin
            be       = 4'b1111;
            size_err = HADDR[1:0] != 2'b00;
         end
         default: size_err = 1'b1;
      endcase
      hit_err = addr_err || size_err;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      commit  = 1'b0;
      case (state_q)
         StIdle: begin
            // A pending transfer in IDLE is in its final data-phase cycle
            commit = pend_q;
            pend_d = 1'b0;
         end
         StWait: begin
            if (cnt_q == 2'd0) state_d = StIdle;
            else               cnt_d   = cnt_q - 2'd1;
         end
         StErr1:  state_d = StErr2;
         StErr2:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (capture) begin
         if (hit_err) begin
            state_d = StErr1;
            pend_d  = 1'b0;
         end else if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 2'(WAIT_STATES - 1);
            pend_d  = 1'b1;
         end else begin
            state_d = StIdle;
            pend_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         pend_q  <= 1'b0;
         write_q <= 1'b0;
         waddr_q <= '0;
         be_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         if (capture) begin
            write_q <= HWRITE;
            waddr_q <= HADDR[ADDR_WIDTH+1:2];
            be_q    <= be;
         end
      end
   end

   // Memory is deliberately left out of reset
   always_ff @(posedge HCLK) begin
      if (commit && write_q && !RESET) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem[waddr_q][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word-address bits, giving 2^ADDR_WIDTH 32-bit words (4 KB at default).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h2000_0000: decode base, aligned to the region size.
REQ-003 SHALL have parameter WAIT_STATES, default 0, legal range 0..3: HREADYOUT-low cycles inserted in each OKAY data phase.
REQ-004 SHALL have port HCLK, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port HSEL, input, 1 bit: slave select.
REQ-007 SHALL have port HADDR, input, 32 bits: transfer address.
REQ-008 SHALL have port HTRANS, input, 2 bits: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-009 SHALL have port HWRITE, input, 1 bit: 1 = write.
REQ-010 SHALL have port HSIZE, input, 3 bits: transfer size (byte, half, word).
REQ-011 SHALL have port HBURST, input, 3 bits: accepted and ignored; every beat is decoded independently.
REQ-012 SHALL have port HPROT, input, 4 bits: accepted and ignored.
REQ-013 SHALL have port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-014 SHALL have port HREADYIN, input, 1 bit: bus-level HREADY.
REQ-015 SHALL have port HREADYOUT, output, 1 bit: this slave's ready.
REQ-016 SHALL have port HRESP, output, 2 bits: 00 OKAY, 01 ERROR.
REQ-017 SHALL have port HRDATA, output, 32 bits: read data.

Function
REQ-018 SHALL capture an address phase only when HSEL=1, HREADYIN=1 and HTRANS[1]=1, registering HADDR, HWRITE and HSIZE.
REQ-019 SHALL treat IDLE or BUSY (with HSEL=1 and HREADYIN=1), and any unselected cycle, as no transfer; the following cycle SHALL be zero-wait OKAY with no memory access.
REQ-020 SHALL flag a captured transfer as error if any of these holds:
- HADDR[31:ADDR_WIDTH+2] differs from BASE_ADDR;
- HSIZE > 2;
- halfword with HADDR[0]=1;
- word with HADDR[1:0] != 0.
REQ-021 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2:
- IDLE + OKAY capture with WAIT_STATES > 0: go to WAIT and load the wait counter with WAIT_STATES-1.
- IDLE + OKAY capture with WAIT_STATES = 0: stay in IDLE; the data phase completes next cycle.
- WAIT: decrement the counter; return to IDLE when it reaches 0.
- Error capture: go to ERR1, then ERR2, then IDLE.
REQ-022 SHALL drive HREADYOUT=0 in WAIT and ERR1, and HREADYOUT=1 in all other states.
REQ-023 SHALL drive HRESP=01 in ERR1 and ERR2, and HRESP=00 in all other states.
REQ-024 SHALL complete an OKAY data phase WAIT_STATES+1 cycles after address capture.
REQ-025 SHALL, for writes, update memory at the clock edge ending the final data-phase cycle, using only the byte lanes selected by HSIZE and HADDR[1:0] (little-endian).
- Byte: lane HADDR[1:0].
- Half: lanes {HADDR[1],0} and {HADDR[1],1}.
- Word: all four lanes.
REQ-026 SHALL, for reads, drive HRDATA = mem[registered word address] (full word, all lanes) during the read data phase, and 32'h0 at all other times, including error phases.
REQ-027 SHALL return the newly written data to a read of the same address issued in the address phase immediately following a write.
REQ-028 SHALL NOT modify memory for errored transfers.
REQ-029 SHALL capture a new address phase in the same cycle as the final data-phase cycle of the previous transfer (pipelined operation).
REQ-030 SHALL NOT capture new address phases while HREADYIN=0.

Reset
REQ-031 SHALL, while RESET=1 and independent of HCLK, force FSM=IDLE, wait counter=0, pending-transfer flag=0, HREADYOUT=1, HRESP=00, HRDATA=32'h0.
REQ-032 SHALL leave memory contents unchanged by reset (not initialised).
REQ-033 SHALL abort a transfer that is in progress when RESET asserts (WAIT, ERR1 or ERR2) with no memory write.
REQ-034 SHALL accept a valid address phase on the first rising edge after RESET deasserts.

Verification
REQ-035 SHALL pass this test: WAIT_STATES=0; word write 0xDEADBEEF to 0x2000_0010, then back-to-back read of 0x2000_0010 -> HRDATA=0xDEADBEEF, HREADYOUT=1 and HRESP=00 throughout.
REQ-036 SHALL pass this test: byte write 0xA5 to 0x2000_0013 over a word holding 0x11223344 -> a subsequent word read returns 0xA5223344.
REQ-037 SHALL pass this test: WAIT_STATES=2; read -> HREADYOUT low for exactly 2 cycles, with data valid on the third data-phase cycle.
REQ-038 SHALL pass this test: write to 0x3000_0000 (out of range) -> ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01); a subsequent read of the aliased offset shows memory unchanged.
REQ-039 SHALL pass this test: misaligned word read at 0x2000_0002 -> two-cycle ERROR response with HRDATA=0.
REQ-040 SHALL pass this test: WAIT_STATES=3; RESET asserted during WAIT of a write -> HREADYOUT=1 and HRESP=00 immediately, and a subsequent read shows the old data.
